// File: rtl/sirv_queue_arb2.sv
// sirv_queue_arb2: two-requester arbiter in front of an 8x8 byte queue.
// Ports: clock/reset, req0/req1 valid/bits/last/ready, queue enq
//   valid/bits/ready, queue count, watermark cfg, grant and txwm flag.
module sirv_queue_arb2 #(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned BCNT_W    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_req0_valid,
    input  logic [7:0] io_req0_bits,
    input  logic       io_req0_last,
    output logic       io_req0_ready,
    input  logic       io_req1_valid,
    input  logic [7:0] io_req1_bits,
    input  logic       io_req1_last,
    output logic       io_req1_ready,
    output logic       io_q_enq_valid,
    output logic [7:0] io_q_enq_bits,
    input  logic       io_q_enq_ready,
    input  logic [3:0] io_q_count,
    input  logic [3:0] io_cfg_txwm,
    output logic [1:0] io_grant,
    output logic       io_txwm_ip
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    localparam logic [BCNT_W:0] MaxB = (BCNT_W + 1)'(MAX_BURST);

    state_e            state_q;
    logic [1:0]        grant_q;
    logic [BCNT_W-1:0] cnt_q;
    logic              last_gnt_q;
    logic              txwm_q;

    logic              own0;
    logic              own1;
    logic              sel_last;
    logic              beat;
    logic [BCNT_W:0]   cnt_inc;
    logic              burst_hit;
    logic              rel;
    logic              cnt_sat;

    // Outputs are forced quiet while reset is high, even though the
    // state register only clears on the next edge.
    assign own0 = (state_q == LOCK0) && !reset;
    assign own1 = (state_q == LOCK1) && !reset;

    assign io_q_enq_valid = own0 ? io_req0_valid :
                            own1 ? io_req1_valid : 1'b0;
    assign io_q_enq_bits  = own0 ? io_req0_bits :
                            own1 ? io_req1_bits : 8'h00;
    assign io_req0_ready  = own0 & io_q_enq_ready;
    assign io_req1_ready  = own1 & io_q_enq_ready;
    assign sel_last       = own0 ? io_req0_last :
                            own1 ? io_req1_last : 1'b0;

    assign beat      = io_q_enq_valid & io_q_enq_ready;
    assign cnt_inc   = {1'b0, cnt_q} + {{BCNT_W{1'b0}}, 1'b1};
    assign burst_hit = (MAX_BURST != 0) && (cnt_inc == MaxB);
    assign rel       = beat & (sel_last | burst_hit);
    // Only reachable with MAX_BURST == 0; otherwise release comes first.
    assign cnt_sat   = &cnt_q;

    assign io_grant   = grant_q;
    assign io_txwm_ip = txwm_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            txwm_q     <= 1'b0;
        end else begin
            txwm_q <= (io_q_count < io_cfg_txwm);
            unique case (state_q)
                IDLE: begin
                    // On a tie the requester not served last wins.
                    if (io_req0_valid && (!io_req1_valid || last_gnt_q)) begin
                        state_q <= LOCK0;
                        grant_q <= 2'b01;
                    end else if (io_req1_valid) begin
                        state_q <= LOCK1;
                        grant_q <= 2'b10;
                    end
                end
                LOCK0, LOCK1: begin
                    if (rel) begin
                        state_q    <= IDLE;
                        grant_q    <= 2'b00;
                        cnt_q      <= '0;
                        last_gnt_q <= (state_q == LOCK1);
                    end else if (beat && !cnt_sat) begin
                        cnt_q <= cnt_inc[BCNT_W-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sirv_queue_arb2.sv
// tb_sirv_queue_arb2: directed self-checking bench for sirv_queue_arb2.
// Drives two byte sources and checks grant, datapath and watermark.
module tb_sirv_queue_arb2;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_req0_valid;
    logic [7:0] io_req0_bits;
    logic       io_req0_last;
    logic       io_req0_ready;
    logic       io_req1_valid;
    logic [7:0] io_req1_bits;
    logic       io_req1_last;
    logic       io_req1_ready;
    logic       io_q_enq_valid;
    logic [7:0] io_q_enq_bits;
    logic       io_q_enq_ready;
    logic [3:0] io_q_count;
    logic [3:0] io_cfg_txwm;
    logic [1:0] io_grant;
    logic       io_txwm_ip;

    always #5 clock = ~clock;

    sirv_queue_arb2 #(.MAX_BURST(8), .BCNT_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_req0_valid (io_req0_valid),
        .io_req0_bits  (io_req0_bits),
        .io_req0_last  (io_req0_last),
        .io_req0_ready (io_req0_ready),
        .io_req1_valid (io_req1_valid),
        .io_req1_bits  (io_req1_bits),
        .io_req1_last  (io_req1_last),
        .io_req1_ready (io_req1_ready),
        .io_q_enq_valid(io_q_enq_valid),
        .io_q_enq_bits (io_q_enq_bits),
        .io_q_enq_ready(io_q_enq_ready),
        .io_q_count    (io_q_count),
        .io_cfg_txwm   (io_cfg_txwm),
        .io_grant      (io_grant),
        .io_txwm_ip    (io_txwm_ip)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] d0[16];
    logic [7:0] d1[16];
    logic       l0[16];
    logic       l1[16];
    int         n0, n1, p0, p1;
    logic       en0, en1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int which, input int n, input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            if (which == 0) begin
                d0[i] = 8'(base + 8'(i));
                l0[i] = 1'b0;
            end else begin
                d1[i] = 8'(base + 8'(i));
                l1[i] = 1'b0;
            end
        end
        if (which == 0) begin
            n0 = n;
            p0 = 0;
        end else begin
            n1 = n;
            p1 = 0;
        end
    endtask

    task automatic drive();
        io_req0_valid = en0 && (p0 < n0);
        io_req0_bits  = (p0 < n0) ? d0[p0] : 8'h00;
        io_req0_last  = (p0 < n0) ? l0[p0] : 1'b0;
        io_req1_valid = en1 && (p1 < n1);
        io_req1_bits  = (p1 < n1) ? d1[p1] : 8'h00;
        io_req1_last  = (p1 < n1) ? l1[p1] : 1'b0;
    endtask

    task automatic cyc(input string tag, input logic qr, input logic [1:0] g,
                       input logic ev, input logic [7:0] b,
                       input logic r0, input logic r1);
        logic a0, a1;
        io_q_enq_ready = qr;
        drive();
        #1;
        chk({tag, " grant"}, 32'(io_grant), 32'(g));
        chk({tag, " enq_valid"}, 32'(io_q_enq_valid), 32'(ev));
        chk({tag, " enq_bits"}, 32'(io_q_enq_bits), 32'(b));
        chk({tag, " ready0"}, 32'(io_req0_ready), 32'(r0));
        chk({tag, " ready1"}, 32'(io_req1_ready), 32'(r1));
        a0 = io_req0_valid & io_req0_ready;
        a1 = io_req1_valid & io_req1_ready;
        @(posedge clock);
        #1;
        if (a0) p0++;
        if (a1) p1++;
    endtask

    initial begin
        reset = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        load(0, 0, 8'h00);
        load(1, 0, 8'h00);
        io_q_enq_ready = 1'b1;
        io_q_count = 4'd0;
        io_cfg_txwm = 4'd0;
        drive();
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst grant", 32'(io_grant), 32'h0);
        chk("rst txwm", 32'(io_txwm_ip), 32'h0);
        chk("rst enq_valid", 32'(io_q_enq_valid), 32'h0);
        reset = 1'b0;

        // single 3-byte packet from req0
        load(0, 3, 8'h00);
        d0[0] = 8'h11;
        d0[1] = 8'h22;
        d0[2] = 8'h33;
        l0[2] = 1'b1;
        en0 = 1'b1;
        cyc("t1 idle", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t1 b0", 1, 2'b01, 1, 8'h11, 1, 0);
        cyc("t1 b1", 1, 2'b01, 1, 8'h22, 1, 0);
        cyc("t1 b2", 1, 2'b01, 1, 8'h33, 1, 0);
        cyc("t1 end", 1, 2'b00, 0, 8'h00, 0, 0);

        // both requesters, 2-byte packets, alternating grants
        load(0, 4, 8'hA0);
        l0[1] = 1'b1;
        l0[3] = 1'b1;
        load(1, 4, 8'hB0);
        l1[1] = 1'b1;
        l1[3] = 1'b1;
        en1 = 1'b1;
        cyc("t2 i0", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t2 b0", 1, 2'b10, 1, 8'hB0, 0, 1);
        cyc("t2 b1", 1, 2'b10, 1, 8'hB1, 0, 1);
        cyc("t2 i1", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t2 a0", 1, 2'b01, 1, 8'hA0, 1, 0);
        cyc("t2 a1", 1, 2'b01, 1, 8'hA1, 1, 0);
        cyc("t2 i2", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t2 b2", 1, 2'b10, 1, 8'hB2, 0, 1);
        cyc("t2 b3", 1, 2'b10, 1, 8'hB3, 0, 1);
        cyc("t2 i3", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t2 a2", 1, 2'b01, 1, 8'hA2, 1, 0);
        cyc("t2 a3", 1, 2'b01, 1, 8'hA3, 1, 0);
        cyc("t2 end", 1, 2'b00, 0, 8'h00, 0, 0);

        // req1 long stream cut at 8 beats, req0 served in between
        load(1, 12, 8'hC0);
        l1[11] = 1'b1;
        load(0, 2, 8'hD0);
        l0[1] = 1'b1;
        cyc("t3 i0", 1, 2'b00, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc("t3 c", 1, 2'b10, 1, 8'(8'hC0 + 8'(i)), 0, 1);
        cyc("t3 i1", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t3 d0", 1, 2'b01, 1, 8'hD0, 1, 0);
        cyc("t3 d1", 1, 2'b01, 1, 8'hD1, 1, 0);
        cyc("t3 i2", 1, 2'b00, 0, 8'h00, 0, 0);
        for (int i = 8; i < 12; i++)
            cyc("t3 c2", 1, 2'b10, 1, 8'(8'hC0 + 8'(i)), 0, 1);
        cyc("t3 end", 1, 2'b00, 0, 8'h00, 0, 0);

        // queue stalls mid-burst; burst limit proves counter held
        load(0, 10, 8'hE0);
        l0[9] = 1'b1;
        load(1, 0, 8'h00);
        en1 = 1'b0;
        cyc("t4 i0", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t4 e0", 1, 2'b01, 1, 8'hE0, 1, 0);
        cyc("t4 stall1", 0, 2'b01, 1, 8'hE1, 0, 0);
        cyc("t4 stall2", 0, 2'b01, 1, 8'hE1, 0, 0);
        for (int i = 1; i < 8; i++)
            cyc("t4 e", 1, 2'b01, 1, 8'(8'hE0 + 8'(i)), 1, 0);
        cyc("t4 i1", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t4 e8", 1, 2'b01, 1, 8'hE8, 1, 0);
        en0 = 1'b0;
        cyc("t4 gap", 1, 2'b01, 0, 8'hE9, 1, 0);
        en0 = 1'b1;
        cyc("t4 e9", 1, 2'b01, 1, 8'hE9, 1, 0);
        cyc("t4 end", 1, 2'b00, 0, 8'h00, 0, 0);

        // watermark flag
        drive();
        io_cfg_txwm = 4'd4;
        io_q_count = 4'd5;
        @(posedge clock);
        #1;
        chk("wm c5", 32'(io_txwm_ip), 32'h0);
        io_q_count = 4'd3;
        #1;
        chk("wm c3 lat", 32'(io_txwm_ip), 32'h0);
        @(posedge clock);
        #1;
        chk("wm c3", 32'(io_txwm_ip), 32'h1);
        io_q_count = 4'd4;
        @(posedge clock);
        #1;
        chk("wm c4", 32'(io_txwm_ip), 32'h0);
        io_cfg_txwm = 4'd0;
        io_q_count = 4'd0;
        @(posedge clock);
        #1;
        chk("wm cfg0", 32'(io_txwm_ip), 32'h0);
        io_cfg_txwm = 4'd9;
        io_q_count = 4'd8;
        @(posedge clock);
        #1;
        chk("wm cfg9", 32'(io_txwm_ip), 32'h1);
        io_cfg_txwm = 4'd0;
        io_q_count = 4'd0;

        // reset in the middle of a req0 packet
        load(0, 9, 8'hF0);
        l0[8] = 1'b1;
        load(1, 0, 8'h00);
        cyc("t6 i0", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t6 f0", 1, 2'b01, 1, 8'hF0, 1, 0);
        reset = 1'b1;
        drive();
        #1;
        chk("t6 rst enq_valid", 32'(io_q_enq_valid), 32'h0);
        chk("t6 rst bits", 32'(io_q_enq_bits), 32'h0);
        chk("t6 rst ready0", 32'(io_req0_ready), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        p0 = 0;
        load(1, 2, 8'h90);
        l1[1] = 1'b1;
        en1 = 1'b1;
        cyc("t6 i1", 1, 2'b00, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc("t6 f", 1, 2'b01, 1, 8'(8'hF0 + 8'(i)), 1, 0);
        cyc("t6 i2", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t6 g0", 1, 2'b10, 1, 8'h90, 0, 1);
        cyc("t6 g1", 1, 2'b10, 1, 8'h91, 0, 1);
        cyc("t6 i3", 1, 2'b00, 0, 8'h00, 0, 0);
        cyc("t6 f8", 1, 2'b01, 1, 8'hF8, 1, 0);
        cyc("t6 end", 1, 2'b00, 0, 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
